interpreter_comm_fifo: RTL and testbench

Buffered, parametrised processor-to-interpreter output channel. It captures the low DATA_W bits of load data whenever a communication-mapped load (MemtoReg & COM) occurs, and queues the words in a DEPTH-entry FIFO. It then replays them to the external interpreter over a strobe protocol: either fixed-timing or acknowledge-based. It sits between the datapath's memory read-back path and the board-level interpreter pins, so back-to-back COM loads are no longer lost.

---
 rtl/interpreter_comm_pkg.sv | 14 +
 rtl/interpreter_comm_fifo_sync.sv | 52 +++++
 rtl/interpreter_comm_fifo.sv | 132 +++++++++++++
 tb/tb_interpreter_comm_fifo.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/interpreter_comm_pkg.sv
// rtl/interpreter_comm_pkg.sv - shared types and sizing helpers for the interpreter output channel
package interpreter_comm_pkg;

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} comm_state_t;

  localparam int COMM_DATA_W_DEF = 15;
  localparam int COMM_DEPTH_DEF  = 8;

  // Bits needed to hold the values 0..max_val (never less than one bit)
  function automatic int comm_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/interpreter_comm_fifo_sync.sv
// rtl/interpreter_comm_fifo_sync.sv - power-of-two synchronous FIFO with wrap-bit pointers
module comm_sync_fifo
  import interpreter_comm_pkg::*;
#(
  parameter int DATA_W = COMM_DATA_W_DEF,
  parameter int DEPTH  = COMM_DEPTH_DEF,
  parameter int CNT_W  = comm_width(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  count,
  output logic [DATA_W-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic              do_push;
  logic              do_pop;

  // Equal indices with differing wrap bits means every slot is occupied
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign count   = CNT_W'(wr_ptr - rd_ptr);
  assign head    = mem[rd_ptr[AW-1:0]];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Pointer advance; reset flushes by realigning the pointers
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents need no reset because the pointers gate visibility
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/interpreter_comm_fifo.sv
// rtl/interpreter_comm_fifo.sv - buffered COM-load capture and strobed replay to the interpreter
module interpreter_comm_fifo
  import interpreter_comm_pkg::*;
#(
  parameter int DATA_W     = COMM_DATA_W_DEF,
  parameter int DEPTH      = COMM_DEPTH_DEF,
  parameter bit USE_ACK    = 1'b0,
  parameter int SETUP_CYC  = 2,
  parameter int STROBE_CYC = 4,
  parameter int HOLD_CYC   = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         MemtoReg,
  input  logic                         COM,
  input  logic [31:0]                  ReadData,
  input  logic                         ack_in,
  input  logic                         clear_ovf,
  output logic [DATA_W-1:0]            data_out,
  output logic                         strobe_out,
  output logic [comm_width(DEPTH)-1:0] count,
  output logic                         busy,
  output logic                         overflow
);

  localparam int CNT_W   = comm_width(DEPTH);
  localparam int MAX_CYC = (SETUP_CYC > STROBE_CYC)
                         ? ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC)
                         : ((STROBE_CYC > HOLD_CYC) ? STROBE_CYC : HOLD_CYC);
  localparam int CYC_W   = comm_width(MAX_CYC);

  comm_state_t       state;
  logic [CYC_W-1:0]  cyc_cnt;
  logic              evt_q;
  logic              evt;
  logic              pop_en;
  logic              fifo_full;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_head;
  logic              hold_done;
  logic              unused_read_bits;

  // Only the low DATA_W bits travel; the rest of the read bus is deliberately dropped
  assign unused_read_bits = ^ReadData;

  assign evt       = MemtoReg && COM && !evt_q;
  assign pop_en    = (state == STROBE) && (USE_ACK ? ack_in : (cyc_cnt == '0));
  assign hold_done = (cyc_cnt == '0) && (!USE_ACK || !ack_in);
  assign busy      = (state != IDLE) || !fifo_empty;

  comm_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .CNT_W  (CNT_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (evt),
    .push_data (ReadData[DATA_W-1:0]),
    .pop       (pop_en),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (count),
    .head      (fifo_head)
  );

  // Rising-edge detect so a load held across several cycles pushes once
  always_ff @(posedge clk) begin
    if (reset) evt_q <= 1'b0;
    else       evt_q <= MemtoReg && COM;
  end

  // Sticky drop flag; a drop in the same cycle as clear wins
  always_ff @(posedge clk) begin
    if (reset)                           overflow <= 1'b0;
    else if (evt && fifo_full && !pop_en) overflow <= 1'b1;
    else if (clear_ovf)                  overflow <= 1'b0;
  end

  // Transfer sequencer: present word, strobe it, then enforce the low gap
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cyc_cnt    <= '0;
      data_out   <= '0;
      strobe_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            data_out <= fifo_head;
            cyc_cnt  <= CYC_W'(SETUP_CYC - 1);
            state    <= SETUP;
          end
        end
        SETUP: begin
          if (cyc_cnt == '0) begin
            strobe_out <= 1'b1;
            cyc_cnt    <= CYC_W'(STROBE_CYC - 1);
            state      <= STROBE;
          end else begin
            cyc_cnt <= cyc_cnt - 1'b1;
          end
        end
        STROBE: begin
          if (pop_en) begin
            strobe_out <= 1'b0;
            cyc_cnt    <= CYC_W'(HOLD_CYC - 1);
            state      <= HOLD;
          end else if (cyc_cnt != '0) begin
            cyc_cnt <= cyc_cnt - 1'b1;
          end
        end
        HOLD: begin
          if (hold_done) begin
            if (!fifo_empty) begin
              data_out <= fifo_head;
              cyc_cnt  <= CYC_W'(SETUP_CYC - 1);
              state    <= SETUP;
            end else begin
              state <= IDLE;
            end
          end else if (cyc_cnt != '0) begin
            cyc_cnt <= cyc_cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_interpreter_comm_fifo.sv
// tb/tb_interpreter_comm_fifo.sv - scoreboard bench for timed and acknowledge-mode channels
module tb_interpreter_comm_fifo;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        MemtoReg = 1'b0;
  logic        com_t = 1'b0;
  logic        com_a = 1'b0;
  logic [31:0] ReadData = '0;
  logic        ack_in = 1'b0;
  logic        clear_ovf = 1'b0;

  logic [14:0] data_t, data_a;
  logic        strobe_t, strobe_a;
  logic [3:0]  count_t, count_a;
  logic        busy_t, busy_a;
  logic        ovf_t, ovf_a;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_t[$];
  logic [31:0] exp_a[$];
  logic        prev_t = 1'b0;
  logic        prev_a = 1'b0;

  always #5 clk = ~clk;

  interpreter_comm_fifo #(.USE_ACK(1'b0)) dut_t (
    .clk(clk), .reset(reset), .MemtoReg(MemtoReg), .COM(com_t), .ReadData(ReadData),
    .ack_in(ack_in), .clear_ovf(clear_ovf), .data_out(data_t), .strobe_out(strobe_t),
    .count(count_t), .busy(busy_t), .overflow(ovf_t)
  );

  interpreter_comm_fifo #(.USE_ACK(1'b1)) dut_a (
    .clk(clk), .reset(reset), .MemtoReg(MemtoReg), .COM(com_a), .ReadData(ReadData),
    .ack_in(ack_in), .clear_ovf(clear_ovf), .data_out(data_a), .strobe_out(strobe_a),
    .count(count_a), .busy(busy_a), .overflow(ovf_a)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every strobe rising edge must carry the oldest expected word
  always @(negedge clk) begin
    if (strobe_t && !prev_t) begin
      if (exp_t.size() == 0) check("t_unexpected_strobe", strobe_t, 1'b0);
      else                   check("t_word", data_t, exp_t.pop_front());
    end
    if (strobe_a && !prev_a) begin
      if (exp_a.size() == 0) check("a_unexpected_strobe", strobe_a, 1'b0);
      else                   check("a_word", data_a, exp_a.pop_front());
    end
    prev_t <= strobe_t;
    prev_a <= strobe_a;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    exp_t.delete();
    exp_a.delete();
  endtask

  task automatic push_word(input bit to_a, input logic [31:0] v);
    ReadData = v;
    MemtoReg = 1'b1;
    com_t = !to_a;
    com_a = to_a;
    step();
    MemtoReg = 1'b0;
    com_t = 1'b0;
    com_a = 1'b0;
    step();
  endtask

  task automatic ack_word(input int extra);
    for (int i = 0; i < 40 && !strobe_a; i++) step();
    check("a_strobe_wait", strobe_a, 1'b1);
    ack_in = 1'b1;
    step();
    check("a_strobe_drop", strobe_a, 1'b0);
    for (int i = 0; i < extra; i++) begin
      step();
      check("a_ack_held_no_strobe", strobe_a, 1'b0);
    end
    ack_in = 1'b0;
  endtask

  task automatic wait_idle(input bit on_a);
    for (int i = 0; i < 200 && (on_a ? busy_a : busy_t); i++) step();
    if (on_a) check("a_idle_wait", busy_a, 1'b0);
    else      check("t_idle_wait", busy_t, 1'b0);
  endtask

  initial begin
    logic [31:0] strobe_ref;
    logic [31:0] busy_ref;
    strobe_ref = 32'b0000_0000_0000_0000_0000_0000_0111_1000;
    busy_ref   = 32'b0000_0000_0000_0000_0000_0001_1111_1111;

    do_reset();
    check("rst_data", data_t, 0);
    check("rst_strobe", strobe_t, 0);
    check("rst_count", count_t, 0);
    check("rst_busy", busy_t, 0);
    check("rst_ovf", ovf_t, 0);

    // COM gating: a non-communication load must never reach the channel
    ReadData = 32'hFFFF_FFFF;
    MemtoReg = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      check("gate_count", count_t, 0);
      check("gate_strobe", strobe_t, 0);
      check("gate_data", data_t, 0);
    end
    MemtoReg = 1'b0;
    step();

    // Single word held for three cycles: one push, 2 setup, 4 strobe, 2 hold
    do_reset();
    ReadData = 32'h0000_1234;
    MemtoReg = 1'b1;
    com_t = 1'b1;
    exp_t.push_back(32'h1234);
    for (int k = 0; k < 10; k++) begin
      step();
      if (k == 2) begin
        MemtoReg = 1'b0;
        com_t = 1'b0;
      end
      check("single_count", count_t, (k < 7) ? 1 : 0);
      check("single_strobe", strobe_t, strobe_ref[k]);
      check("single_busy", busy_t, busy_ref[k]);
      check("single_data", data_t, (k == 0) ? 0 : 32'h1234);
    end
    check("single_sb_empty", exp_t.size(), 0);

    // Burst into a stalled acknowledge channel: 8 kept, 2 dropped
    do_reset();
    for (int i = 1; i <= 10; i++) begin
      if (i <= 8) exp_a.push_back(i);
      push_word(1'b1, i);
    end
    check("burst_count", count_a, 8);
    check("burst_ovf", ovf_a, 1);
    for (int i = 0; i < 8; i++) ack_word((i == 0) ? 3 : 0);
    wait_idle(1'b1);
    check("burst_drained", count_a, 0);
    check("burst_sb_empty", exp_a.size(), 0);
    check("ovf_sticky", ovf_a, 1);
    clear_ovf = 1'b1;
    step();
    clear_ovf = 1'b0;
    check("ovf_cleared", ovf_a, 0);

    // Full FIFO with a push landing on the strobe-exit pop
    for (int i = 1; i <= 8; i++) begin
      exp_a.push_back(32'h100 + i);
      push_word(1'b1, 32'h100 + i);
    end
    for (int i = 0; i < 40 && !strobe_a; i++) step();
    check("full_strobe_up", strobe_a, 1);
    check("full_count", count_a, 8);
    ReadData = 32'h0000_7ABC;
    MemtoReg = 1'b1;
    com_a = 1'b1;
    ack_in = 1'b1;
    exp_a.push_back(32'h7ABC);
    step();
    MemtoReg = 1'b0;
    com_a = 1'b0;
    ack_in = 1'b0;
    check("pushpop_count", count_a, 8);
    check("pushpop_ovf", ovf_a, 0);
    for (int i = 0; i < 8; i++) ack_word(0);
    wait_idle(1'b1);
    check("pushpop_sb_empty", exp_a.size(), 0);

    // Reset during a strobe with three words queued
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      exp_t.push_back(32'h50 + i);
      push_word(1'b0, 32'h50 + i);
    end
    check("mid_strobe", strobe_t, 1);
    check("mid_count", count_t, 3);
    reset = 1'b1;
    step();
    reset = 1'b0;
    exp_t.delete();
    check("mid_rst_strobe", strobe_t, 0);
    check("mid_rst_count", count_t, 0);
    check("mid_rst_data", data_t, 0);
    check("mid_rst_busy", busy_t, 0);
    exp_t.push_back(32'h2A5A);
    push_word(1'b0, 32'h0001_2A5A);
    wait_idle(1'b0);
    check("after_rst_sb_empty", exp_t.size(), 0);
    check("after_rst_data", data_t, 32'h2A5A);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
